// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Next-address generator for the program counter. Each cycle it decodes a
// sequencing op, computes the address the PC register takes at the next edge
// and keeps a small LIFO return-address stack for CALL/RET.
//
// Parameters
//   WIDTH        address width
//   STACK_DEPTH  number of return-address stack entries (>= 1)
//   RESET_ADDR   PC value after reset
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   stall    in   hold all state this cycle
//   op       in   000 INC, 001 JMP, 010 BRZ, 011 CALL, 100 RET, 101 HALT,
//                 110/111 behave as INC
//   cond     in   BRZ taken when 1
//   target   in   JMP/BRZ/CALL destination
//   pc       out  current program counter (registered)
//   pc_next  out  value pc takes at the next edge (combinational)
//   depth    out  number of valid stack entries (registered)
//   halted   out  state is HALT (registered)
//   fault    out  state is FAULT, sticky until reset (registered)
// -----------------------------------------------------------------------------
module pc_sequencer #(
   parameter int               WIDTH       = 8,
   parameter int               STACK_DEPTH = 4,
   parameter logic [WIDTH-1:0] RESET_ADDR  = '0
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               stall,
   input  logic [2:0]                         op,
   input  logic                               cond,
   input  logic [WIDTH-1:0]                   target,
   output logic [WIDTH-1:0]                   pc,
   output logic [WIDTH-1:0]                   pc_next,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
   output logic                               halted,
   output logic                               fault
);

   localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
   // A single-entry stack still needs a one-bit index.
   localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   localparam logic [2:0] OP_INC  = 3'b000;
   localparam logic [2:0] OP_JMP  = 3'b001;
   localparam logic [2:0] OP_BRZ  = 3'b010;
   localparam logic [2:0] OP_CALL = 3'b011;
   localparam logic [2:0] OP_RET  = 3'b100;
   localparam logic [2:0] OP_HALT = 3'b101;

   localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_HALT  = 2'd1,
      S_FAULT = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     pc_q, pc_d;
   logic [DEPTH_W-1:0]   depth_q, depth_d;
   logic                 halted_q, halted_d;
   logic                 fault_q, fault_d;

   // Return-address storage; contents are don't-care after reset, only
   // depth_q says which entries are valid.
   logic [WIDTH-1:0]     stack_q [STACK_DEPTH];

   logic [WIDTH-1:0]     pc_inc;
   logic [IDX_W-1:0]     push_idx;
   logic [IDX_W-1:0]     top_idx;
   logic [WIDTH-1:0]     stack_top;
   logic                 push_en;

   // pc + 1 wraps naturally at 2^WIDTH.
   assign pc_inc    = pc_q + WIDTH'(1);
   assign push_idx  = IDX_W'(depth_q);
   assign top_idx   = IDX_W'(depth_q - DEPTH_W'(1));
   assign stack_top = stack_q[top_idx];

   // ---------------------------------------------------------------------------
   // Next-state decode. reset is deliberately absent here so pc_next has no
   // combinational path from reset; reset only acts on the flops.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      depth_d = depth_q;
      push_en = 1'b0;

      if (state_q == S_RUN && !stall) begin
         unique case (op)
            OP_JMP: begin
               pc_d = target;
            end
            OP_BRZ: begin
               pc_d = cond ? target : pc_inc;
            end
            OP_CALL: begin
               if (depth_q < DEPTH_FULL) begin
                  push_en = 1'b1;
                  depth_d = depth_q + DEPTH_W'(1);
                  pc_d    = target;
               end else begin
                  // Overflow: nothing is pushed, pc holds, block faults.
                  state_d = S_FAULT;
               end
            end
            OP_RET: begin
               if (depth_q != '0) begin
                  // Pop only moves depth; the entry itself is left in place.
                  depth_d = depth_q - DEPTH_W'(1);
                  pc_d    = stack_top;
               end else begin
                  state_d = S_FAULT;
               end
            end
            OP_HALT: begin
               state_d = S_HALT;
            end
            default: begin
               // INC and the two spare encodings.
               pc_d = pc_inc;
            end
         endcase
      end

      halted_d = (state_d == S_HALT);
      fault_d  = (state_d == S_FAULT);
   end

   assign pc_next = pc_d;

   // ---------------------------------------------------------------------------
   // Control and PC registers.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_RUN;
         pc_q     <= RESET_ADDR;
         depth_q  <= '0;
         halted_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         depth_q  <= depth_d;
         halted_q <= halted_d;
         fault_q  <= fault_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Stack storage: no reset, written only on a push that reset does not
   // override.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push_en && !reset) begin
         stack_q[push_idx] <= pc_inc;
      end
   end

   assign pc     = pc_q;
   assign depth  = depth_q;
   assign halted = halted_q;
   assign fault  = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed bench for pc_sequencer: a table of {inputs, expected outputs} rows
// applied one per clock, plus hand-written sequences for the 300-cycle INC
// wrap and the 10-cycle HALT hold.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

   localparam logic [2:0] INC  = 3'd0;
   localparam logic [2:0] JMP  = 3'd1;
   localparam logic [2:0] BRZ  = 3'd2;
   localparam logic [2:0] CALL = 3'd3;
   localparam logic [2:0] RET  = 3'd4;
   localparam logic [2:0] HALT = 3'd5;

   logic       clk;
   logic       reset;
   logic       stall;
   logic [2:0] op;
   logic       cond;
   logic [7:0] target;
   logic [7:0] pc;
   logic [7:0] pc_next;
   logic [2:0] depth;
   logic       halted;
   logic       fault;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       rst;
      logic       stl;
      logic [2:0] op;
      logic       cnd;
      logic [7:0] tgt;
      logic       chk_nx;
      logic [7:0] nx;
      logic [7:0] pc;
      logic [2:0] dep;
      logic       h;
      logic       f;
   } vec_t;

   vec_t tbl_a[$];
   vec_t tbl_b[$];

   pc_sequencer #(
      .WIDTH      (8),
      .STACK_DEPTH(4),
      .RESET_ADDR (8'h00)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .stall  (stall),
      .op     (op),
      .cond   (cond),
      .target (target),
      .pc     (pc),
      .pc_next(pc_next),
      .depth  (depth),
      .halted (halted),
      .fault  (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int idx, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic add_a(input logic r, input logic s, input logic [2:0] o, input logic c,
                        input logic [7:0] t, input logic cn, input logic [7:0] n,
                        input logic [7:0] p, input logic [2:0] d, input logic h,
                        input logic f);
      vec_t v;
      v = '{rst:r, stl:s, op:o, cnd:c, tgt:t, chk_nx:cn, nx:n, pc:p, dep:d, h:h, f:f};
      tbl_a.push_back(v);
   endtask

   task automatic add_b(input logic r, input logic s, input logic [2:0] o, input logic c,
                        input logic [7:0] t, input logic cn, input logic [7:0] n,
                        input logic [7:0] p, input logic [2:0] d, input logic h,
                        input logic f);
      vec_t v;
      v = '{rst:r, stl:s, op:o, cnd:c, tgt:t, chk_nx:cn, nx:n, pc:p, dep:d, h:h, f:f};
      tbl_b.push_back(v);
   endtask

   // Applies one row: drive inputs just after an edge, check pc_next before the
   // next edge, then check the registered outputs just after it.
   task automatic apply(input vec_t v, input int idx);
      reset  = v.rst;
      stall  = v.stl;
      op     = v.op;
      cond   = v.cnd;
      target = v.tgt;
      #1;
      if (v.chk_nx) chk("pc_next", idx, int'(pc_next), int'(v.nx));
      @(posedge clk);
      #1;
      chk("pc", idx, int'(pc), int'(v.pc));
      chk("depth", idx, int'(depth), int'(v.dep));
      chk("halted", idx, int'(halted), int'(v.h));
      chk("fault", idx, int'(fault), int'(v.f));
   endtask

   initial begin
      reset  = 1'b1;
      stall  = 1'b0;
      op     = INC;
      cond   = 1'b0;
      target = 8'h00;

      // ---- table A: reset, jump/branch, call/ret, overflow, underflow, HALT ----
      //     rst stl op    c  tgt    cn nx     pc     d  h  f
      add_a(1, 0, INC,  0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0);
      add_a(1, 0, CALL, 0, 8'h77, 0, 8'h00, 8'h00, 0, 0, 0);

      // ---- table B: starts at pc 0x2C after the INC run ----
      add_b(0, 0, JMP,  0, 8'h10, 1, 8'h10, 8'h10, 0, 0, 0);
      add_b(0, 0, JMP,  1, 8'h80, 1, 8'h80, 8'h80, 0, 0, 0);
      add_b(0, 0, BRZ,  0, 8'h20, 1, 8'h81, 8'h81, 0, 0, 0);
      add_b(0, 0, BRZ,  1, 8'h20, 1, 8'h20, 8'h20, 0, 0, 0);
      add_b(0, 0, JMP,  0, 8'h05, 1, 8'h05, 8'h05, 0, 0, 0);
      add_b(0, 0, CALL, 0, 8'h40, 1, 8'h40, 8'h40, 1, 0, 0);
      add_b(0, 0, CALL, 1, 8'h60, 1, 8'h60, 8'h60, 2, 0, 0);
      add_b(0, 0, RET,  0, 8'h99, 1, 8'h41, 8'h41, 1, 0, 0);
      add_b(0, 0, RET,  0, 8'h00, 1, 8'h06, 8'h06, 0, 0, 0);
      add_b(0, 0, JMP,  0, 8'hFF, 1, 8'hFF, 8'hFF, 0, 0, 0);
      add_b(0, 0, CALL, 0, 8'h40, 1, 8'h40, 8'h40, 1, 0, 0);
      add_b(0, 0, RET,  0, 8'h00, 1, 8'h00, 8'h00, 0, 0, 0);
      // INC ignores cond/target; spare encodings behave as INC.
      add_b(0, 0, INC,  1, 8'h99, 1, 8'h01, 8'h01, 0, 0, 0);
      add_b(0, 0, 3'd6, 1, 8'h99, 1, 8'h02, 8'h02, 0, 0, 0);
      add_b(0, 0, 3'd7, 0, 8'h99, 1, 8'h03, 8'h03, 0, 0, 0);
      // Fill the stack: pushes 0x04, 0x11, 0x21, 0x31.
      add_b(0, 0, CALL, 0, 8'h10, 1, 8'h10, 8'h10, 1, 0, 0);
      add_b(0, 0, CALL, 0, 8'h20, 1, 8'h20, 8'h20, 2, 0, 0);
      add_b(0, 0, CALL, 0, 8'h30, 1, 8'h30, 8'h30, 3, 0, 0);
      add_b(0, 0, CALL, 0, 8'h40, 1, 8'h40, 8'h40, 4, 0, 0);
      // Stalled overflow does not fault; unstalled one does.
      add_b(0, 1, CALL, 0, 8'h50, 1, 8'h40, 8'h40, 4, 0, 0);
      add_b(0, 0, CALL, 0, 8'h50, 1, 8'h40, 8'h40, 4, 0, 1);
      add_b(0, 0, RET,  0, 8'h00, 1, 8'h40, 8'h40, 4, 0, 1);
      add_b(0, 0, JMP,  0, 8'h77, 1, 8'h40, 8'h40, 4, 0, 1);
      add_b(0, 0, HALT, 0, 8'h00, 1, 8'h40, 8'h40, 4, 0, 1);
      add_b(1, 0, CALL, 0, 8'h66, 0, 8'h00, 8'h00, 0, 0, 0);
      // Underflow, stalled first.
      add_b(0, 1, RET,  0, 8'h00, 1, 8'h00, 8'h00, 0, 0, 0);
      add_b(0, 0, RET,  0, 8'h00, 1, 8'h00, 8'h00, 0, 0, 1);
      add_b(0, 0, INC,  0, 8'h00, 1, 8'h00, 8'h00, 0, 0, 1);
      add_b(1, 0, INC,  0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0);
      // Reach HALT at 0x33.
      add_b(0, 0, JMP,  0, 8'h33, 1, 8'h33, 8'h33, 0, 0, 0);
      add_b(0, 0, HALT, 0, 8'h00, 1, 8'h33, 8'h33, 0, 1, 0);

      // ---- table C (after HALT hold): stall, reset-with-CALL, LIFO ----
      //     rst stl op    c  tgt    cn nx     pc     d  h  f
      // (stored in tbl_a after the reset rows; applied from index 2)
      add_a(1, 0, INC,  0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0);
      add_a(0, 1, CALL, 0, 8'h50, 1, 8'h00, 8'h00, 0, 0, 0);
      add_a(0, 1, CALL, 0, 8'h50, 1, 8'h00, 8'h00, 0, 0, 0);
      add_a(0, 1, CALL, 0, 8'h50, 1, 8'h00, 8'h00, 0, 0, 0);
      add_a(0, 0, CALL, 0, 8'h50, 1, 8'h50, 8'h50, 1, 0, 0);
      add_a(1, 0, CALL, 0, 8'h60, 0, 8'h00, 8'h00, 0, 0, 0);
      // Bottom entry must survive pops and re-pushes above it.
      add_a(0, 0, CALL, 0, 8'h10, 1, 8'h10, 8'h10, 1, 0, 0);
      add_a(0, 0, CALL, 0, 8'h20, 1, 8'h20, 8'h20, 2, 0, 0);
      add_a(0, 0, RET,  0, 8'h00, 1, 8'h11, 8'h11, 1, 0, 0);
      add_a(0, 0, CALL, 0, 8'h30, 1, 8'h30, 8'h30, 2, 0, 0);
      add_a(0, 0, RET,  0, 8'h00, 1, 8'h12, 8'h12, 1, 0, 0);
      add_a(0, 0, RET,  0, 8'h00, 1, 8'h01, 8'h01, 0, 0, 0);

      @(posedge clk);
      #1;

      // Reset rows.
      for (int i = 0; i < 2; i++) apply(tbl_a[i], i);

      // 300 INC cycles: pc counts up, wraps at 256, ends at 0x2C.
      reset = 1'b0;
      stall = 1'b0;
      op    = INC;
      for (int i = 1; i <= 300; i++) begin
         @(posedge clk);
         #1;
         chk("inc_pc", i, int'(pc), i % 256);
      end
      chk("inc_final", 300, int'(pc), 'h2C);

      for (int i = 0; i < tbl_b.size(); i++) apply(tbl_b[i], 100 + i);

      // HALT hold: 10 cycles of INC/JMP leave pc at 0x33.
      for (int i = 0; i < 10; i++) begin
         op     = (i % 2 == 0) ? INC : JMP;
         target = 8'hA5;
         cond   = 1'b1;
         #1;
         chk("halt_nx", 200 + i, int'(pc_next), 'h33);
         @(posedge clk);
         #1;
         chk("halt_pc", 200 + i, int'(pc), 'h33);
         chk("halt_flag", 200 + i, int'(halted), 1);
      end

      for (int i = 2; i < tbl_a.size(); i++) apply(tbl_a[i], 300 + i);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Run-time guard so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
